// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of one single-port on-chip RAM.
// At most one RAM command is issued per cycle. The port that loses
// contention is stalled with waitrequest. Read data returns to the port
// that issued the read through a fixed-latency pipeline. Accesses at or
// above MEM_DEPTH still complete, but writes are dropped and reads return
// zero. RD_LAT must be 1 (unregistered RAM q) or 2 (registered RAM q).
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 5120,
  parameter int RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // port 1
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  mem_clken
);

  // One bit wider than the address so a depth equal to 2**ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  logic                 req0, req1;
  logic                 gnt0, gnt1, gnt_any;
  logic                 gnt_wr, gnt_rd;
  logic                 in_range;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W/8-1:0]  sel_be;
  logic [DATA_W-1:0]    sel_wdata;

  // 1 = port 1 was granted last, so port 0 wins the next contention.
  logic                 last_grant_q;

  // Read-return pipeline: one {valid, port, out-of-range} entry per stage.
  logic [RD_LAT-1:0]    vld_q, port_q, oor_q;
  logic                 vld_d, port_d, oor_d;

  logic                 vld_last, port_last, oor_last;
  logic [DATA_W-1:0]    ret_data;
  logic                 rdv0, rdv1;
  logic [DATA_W-1:0]    rd0_q, rd1_q;

  // Arbitration and command mux; nothing is granted while reset is held.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    gnt0      = !reset & req0 & (!req1 | last_grant_q);
    gnt1      = !reset & req1 & !gnt0;
    gnt_any   = gnt0 | gnt1;
    sel_addr  = gnt1 ? m1_address    : m0_address;
    sel_be    = gnt1 ? m1_byteenable : m0_byteenable;
    sel_wdata = gnt1 ? m1_writedata  : m0_writedata;
    // A request with both read and write set is treated as a write.
    gnt_wr    = gnt1 ? m1_write : (gnt0 & m0_write);
    gnt_rd    = gnt_any & !gnt_wr;
    in_range  = {1'b0, sel_addr} < DEPTH_C;
    vld_d     = gnt_rd;
    port_d    = gnt1;
    oor_d     = !in_range;
  end

  assign m0_waitrequest = reset | (req0 & !gnt0);
  assign m1_waitrequest = reset | (req1 & !gnt1);

  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  assign mem_chipselect = gnt_any & in_range;
  assign mem_write      = gnt_wr & in_range;
  assign mem_clken      = 1'b1;

  // Remember which port was granted on every grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (gnt_any) begin
      last_grant_q <= gnt1;
    end
  end

  // Valid bits of the read-return pipeline; cleared so in-flight reads vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_d;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Port and out-of-range tags travel alongside the valid bits.
  always_ff @(posedge clk) begin
    port_q[0] <= port_d;
    oor_q[0]  <= oor_d;
    for (int i = 1; i < RD_LAT; i++) begin
      port_q[i] <= port_q[i-1];
      oor_q[i]  <= oor_q[i-1];
    end
  end

  // Last stage lines up with RAM q; out-of-range reads return zero.
  always_comb begin
    vld_last  = vld_q[RD_LAT-1] & !reset;
    port_last = port_q[RD_LAT-1];
    oor_last  = oor_q[RD_LAT-1];
    ret_data  = oor_last ? '0 : mem_readdata;
    rdv0      = vld_last & !port_last;
    rdv1      = vld_last & port_last;
  end

  // Hold the most recent read data per port between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (rdv0) rd0_q <= ret_data;
      if (rdv1) rd1_q <= ret_data;
    end
  end

  assign m0_readdatavalid = rdv0;
  assign m1_readdatavalid = rdv1;
  assign m0_readdata      = rdv0 ? ret_data : rd0_q;
  assign m1_readdata      = rdv1 ? ret_data : rd1_q;

endmodule
